// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_pkg
//  Purpose  : Shared types for the UART command scheduler: command codes,
//             link FSM states, ASCII command bytes and the byte decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_FLAP  = 2'd0,
    CMD_START = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_RESET = 2'd3
  } cmd_t;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_t;

  localparam logic [7:0] C_ASCII_ONE  = 8'h31;
  localparam logic [7:0] C_ASCII_S_UC = 8'h53;
  localparam logic [7:0] C_ASCII_S_LC = 8'h73;
  localparam logic [7:0] C_ASCII_P_UC = 8'h50;
  localparam logic [7:0] C_ASCII_P_LC = 8'h70;
  localparam logic [7:0] C_ASCII_R_UC = 8'h52;
  localparam logic [7:0] C_ASCII_R_LC = 8'h72;

  typedef struct packed {
    logic valid;
    cmd_t code;
  } dec_t;

  // Map a received byte to a command; valid=0 for bytes that carry no command.
  function automatic dec_t decode_byte(input logic [7:0] b);
    dec_t r;
    r.valid = 1'b1;
    r.code  = CMD_FLAP;
    case (b)
      C_ASCII_ONE:                r.code  = CMD_FLAP;
      C_ASCII_S_UC, C_ASCII_S_LC: r.code  = CMD_START;
      C_ASCII_P_UC, C_ASCII_P_LC: r.code  = CMD_PAUSE;
      C_ASCII_R_UC, C_ASCII_R_LC: r.code  = CMD_RESET;
      default:                    r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_scheduler_if
//  Purpose  : Byte input from the UART receiver and the command valid/ready
//             handshake towards the game FSM.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_scheduler_if;
  import uart_cmd_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_valid;
  cmd_t       cmd_code;
  logic       cmd_ready;

  // Upstream byte source and downstream command consumer.
  modport master (output rx_data, output rx_valid, output cmd_ready,
                  input  cmd_valid, input cmd_code);

  // The scheduler itself.
  modport slave  (input  rx_data, input rx_valid, input cmd_ready,
                  output cmd_valid, output cmd_code);
endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_fifo
//  Purpose  : Small synchronous FIFO of cmd_t with flush. A push and a pop in
//             the same cycle on a full queue both succeed. Flush with push
//             leaves exactly the pushed entry in the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  cmd_t                     data_i,
  output cmd_t                     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          w_pop;
  logic          w_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign level_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pops on an empty queue are ignored; a push into a full queue needs a pop.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  // Storage, pointers and occupancy; flush restarts the queue from slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= CMD_FLAP;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      if (push_i) begin
        mem_q[0] <= data_i;
        wr_ptr_q <= AW'(1);
        count_q  <= (AW+1)'(1);
      end else begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_scheduler
//  Purpose  : Decodes ASCII command bytes from the UART receiver, rate-limits
//             FLAPs, tracks pause mode, queues commands for the game FSM and
//             reports link activity and a saturating dropped-command count.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_scheduler
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ      = 65_000_000,
  parameter int CLICK_GAP_CYC = 3_250_000,
  parameter int LINK_TO_CYC   = 65_000_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_cmd_scheduler_if.slave           cmd_if,
  output logic                          paused_o,
  output logic                          link_active_o,
  output logic [7:0]                    drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int GAP_W  = $clog2(CLICK_GAP_CYC + 1);
  localparam int LINK_W = $clog2(LINK_TO_CYC + 1);

  if ((CLK_FREQ < 1) || (CLICK_GAP_CYC < 1) || (LINK_TO_CYC < 1) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
    $error("uart_cmd_scheduler: illegal parameter value");
  end

  dec_t              w_dec;
  logic              w_is_flap;
  logic              w_flap_drop;
  logic              w_d_load;
  logic              w_enq_reset;
  logic              w_push_ok;
  logic              w_full_drop;
  logic              w_full;
  logic              w_empty;
  cmd_t              w_head;
  logic [1:0]        w_drop_inc;
  logic [8:0]        w_drop_sum;

  logic              d_valid_q,  d_valid_d;
  cmd_t              d_code_q,   d_code_d;
  logic              paused_q,   paused_d;
  logic [GAP_W-1:0]  gap_q,      gap_d;
  logic [7:0]        drop_q,     drop_d;
  link_state_t       link_q,     link_d;
  logic [LINK_W-1:0] link_cnt_q, link_cnt_d;

  // FLAPs are filtered at decode time, before they can occupy stage D.
  assign w_dec       = decode_byte(cmd_if.rx_data);
  assign w_is_flap   = cmd_if.rx_valid && w_dec.valid && (w_dec.code == CMD_FLAP);
  assign w_flap_drop = w_is_flap && ((gap_q != '0) || paused_q);
  assign w_d_load    = cmd_if.rx_valid && w_dec.valid && !w_flap_drop;

  // RESET bypasses the full check because it flushes the queue first.
  assign w_enq_reset = d_valid_q && (d_code_q == CMD_RESET);
  assign w_push_ok   = d_valid_q && (w_enq_reset || !w_full || (cmd_if.cmd_ready && !w_empty));
  assign w_full_drop = d_valid_q && !w_push_ok;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (d_valid_q),
    .pop_i   (cmd_if.cmd_ready),
    .flush_i (w_enq_reset),
    .data_i  (d_code_q),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (fifo_level_o)
  );

  // Next state of the decode stage, pause mode, FLAP gap timer and drop counter.
  always_comb begin
    d_valid_d = w_d_load;
    d_code_d  = w_dec.code;

    paused_d = paused_q;
    if (w_push_ok) begin
      case (d_code_q)
        CMD_PAUSE:            paused_d = !paused_q;
        CMD_START, CMD_RESET: paused_d = 1'b0;
        default:              paused_d = paused_q;
      endcase
    end

    gap_d = gap_q;
    if (w_enq_reset)        gap_d = '0;
    else if (w_is_flap && !w_flap_drop) gap_d = GAP_W'(CLICK_GAP_CYC - 1);
    else if (gap_q != '0)   gap_d = gap_q - 1'b1;

    // A filtered FLAP and a full-queue drop can coincide in one cycle.
    w_drop_inc = 2'(w_flap_drop) + 2'(w_full_drop);
    w_drop_sum = {1'b0, drop_q} + 9'(w_drop_inc);
    drop_d     = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  // Link FSM: any received byte restarts the activity timeout.
  always_comb begin
    link_d     = link_q;
    link_cnt_d = link_cnt_q;
    if (cmd_if.rx_valid) begin
      link_d     = LINK_UP;
      link_cnt_d = LINK_W'(LINK_TO_CYC - 1);
    end else if (link_q == LINK_UP) begin
      if (link_cnt_q == '0) link_d = LINK_DOWN;
      else                  link_cnt_d = link_cnt_q - 1'b1;
    end
  end

  // State registers; reset also discards a command held in stage D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid_q  <= 1'b0;
      d_code_q   <= CMD_FLAP;
      paused_q   <= 1'b0;
      gap_q      <= '0;
      drop_q     <= '0;
      link_q     <= LINK_DOWN;
      link_cnt_q <= '0;
    end else begin
      d_valid_q  <= d_valid_d;
      d_code_q   <= d_code_d;
      paused_q   <= paused_d;
      gap_q      <= gap_d;
      drop_q     <= drop_d;
      link_q     <= link_d;
      link_cnt_q <= link_cnt_d;
    end
  end

  assign cmd_if.cmd_valid = !w_empty;
  assign cmd_if.cmd_code  = w_head;
  assign paused_o         = paused_q;
  assign link_active_o    = (link_q == LINK_UP);
  assign drop_cnt_o       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_scheduler
//  Purpose  : Self-checking bench for uart_cmd_scheduler with a queue-based
//             reference model driven by timestamps of received bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_scheduler;
  import uart_cmd_pkg::*;

  localparam int GAP   = 20;
  localparam int LTO   = 50;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       paused;
  logic       link_active;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_cmd_scheduler_if ifc ();

  uart_cmd_scheduler #(
    .CLK_FREQ      (65_000_000),
    .CLICK_GAP_CYC (GAP),
    .LINK_TO_CYC   (LTO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_if        (ifc),
    .paused_o      (paused),
    .link_active_o (link_active),
    .drop_cnt_o    (drop_cnt),
    .fifo_level_o  (fifo_level)
  );

  // ---------------- reference model (edge-indexed timestamps) ----------------
  int   cyc;
  int   last_flap;
  int   last_rx;
  bit   m_paused;
  int   m_drop;
  cmd_t mq[$];
  bit   pend_v;
  cmd_t pend_c;

  function automatic bit m_decode(input logic [7:0] b, output cmd_t c);
    bit ok = 1'b1;
    c = CMD_FLAP;
    case (b)
      8'h31:        c = CMD_FLAP;
      8'h53, 8'h73: c = CMD_START;
      8'h50, 8'h70: c = CMD_PAUSE;
      8'h52, 8'h72: c = CMD_RESET;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic void model_reset();
    cyc = 0; last_flap = -100000; last_rx = -100000;
    m_paused = 1'b0; m_drop = 0; mq.delete(); pend_v = 1'b0; pend_c = CMD_FLAP;
  endfunction

  function automatic void m_count_drop();
    if (m_drop < 255) m_drop++;
  endfunction

  // One clock edge: decide the new byte using pre-edge state, then enqueue the
  // command decoded on the previous edge, then pop.
  function automatic void model_edge(input bit v, input logic [7:0] d, input bit rdy);
    bit   pop_now = rdy && (mq.size() > 0);
    bit   take = 1'b0;
    cmd_t c = CMD_FLAP;
    if (v) begin
      last_rx = cyc;
      if (m_decode(d, c)) begin
        if (c == CMD_FLAP && ((cyc - last_flap) < GAP || m_paused)) m_count_drop();
        else take = 1'b1;
        if (take && c == CMD_FLAP) last_flap = cyc;
      end
    end
    if (pend_v) begin
      if (pend_c == CMD_RESET) begin
        mq.delete(); mq.push_back(CMD_RESET); m_paused = 1'b0; last_flap = -100000;
      end else begin
        if (pop_now) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          mq.push_back(pend_c);
          if (pend_c == CMD_PAUSE) m_paused = !m_paused;
          if (pend_c == CMD_START) m_paused = 1'b0;
        end else m_count_drop();
      end
      pop_now = 1'b0;
    end
    if (pop_now) void'(mq.pop_front());
    pend_v = take; pend_c = c;
    cyc++;
  endfunction

  function automatic bit m_link();
    return (cyc - 1 - last_rx) < LTO;
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic step();
    bit v, r;
    logic [7:0] d;
    v = ifc.rx_valid; d = ifc.rx_data; r = ifc.cmd_ready;
    @(posedge clk);
    if (rst_n) model_edge(v, d, r); else model_reset();
    #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    ifc.rx_data = b; ifc.rx_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ifc.rx_data = 8'h00; ifc.rx_valid = 1'b0; ifc.cmd_ready = 1'b0;
    rst_n = 1'b0; model_reset();
    idle(3);
    checks++; if (ifc.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ifc.cmd_valid); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %0b want 0", paused); end
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL reset_link got %0b want 0", link_active); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_flap();
    ifc.cmd_ready = 1'b1;
    send(8'h31);
    checks++; if (ifc.cmd_valid !== 1'b0) begin errors++; $display("FAIL flap_lat1 valid got %0b want 0", ifc.cmd_valid); end
    step();
    checks++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== CMD_FLAP) begin errors++;
      $display("FAIL flap_lat2 valid/code got %0b/%0d want 1/%0d", ifc.cmd_valid, ifc.cmd_code, CMD_FLAP); end
    step();
    checks++; if (ifc.cmd_valid !== 1'b0) begin errors++; $display("FAIL flap_popped valid got %0b want 0", ifc.cmd_valid); end
  endtask

  task automatic test_flap_gap();
    int d0, pops;
    ifc.cmd_ready = 1'b1;
    idle(GAP + 5);
    d0 = m_drop; pops = 0;
    for (int t = 0; t < 32; t++) begin
      if (t == 0 || t == 5 || t == 25) send(8'h31); else step();
      if (ifc.cmd_valid && ifc.cmd_code == CMD_FLAP) pops++;
    end
    checks++; if (pops != 2) begin errors++; $display("FAIL gap_flaps_out got %0d want 2", pops); end
    checks++; if (drop_cnt !== 8'(d0 + 1)) begin errors++; $display("FAIL gap_drop got %0d want %0d", drop_cnt, d0 + 1); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] b [5]  = '{8'h53, 8'h50, 8'h70, 8'h53, 8'h53};
    bit         ep [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int         el [5] = '{1, 2, 3, 4, 4};
    cmd_t       ec [4] = '{CMD_START, CMD_PAUSE, CMD_PAUSE, CMD_START};
    int d0;
    ifc.cmd_ready = 1'b0;
    idle(2);
    d0 = m_drop;
    for (int i = 0; i < 5; i++) begin
      send(b[i]); step();
      checks++; if (fifo_level !== 3'(el[i]) || paused !== ep[i]) begin errors++;
        $display("FAIL full_fill[%0d] level/paused got %0d/%0b want %0d/%0b", i, fifo_level, paused, el[i], ep[i]); end
    end
    checks++; if (drop_cnt !== 8'(d0 + 1)) begin errors++; $display("FAIL full_drop got %0d want %0d", drop_cnt, d0 + 1); end
    ifc.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== ec[i]) begin errors++;
        $display("FAIL full_order[%0d] valid/code got %0b/%0d want 1/%0d", i, ifc.cmd_valid, ifc.cmd_code, ec[i]); end
      step();
    end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL full_drained level got %0d want 0", fifo_level); end
  endtask

  task automatic test_reset_cmd();
    int d0;
    ifc.cmd_ready = 1'b0;
    idle(GAP + 2);
    send(8'h31); step();
    send(8'h53); step();
    send(8'h50); step();
    checks++; if (fifo_level !== 3'd3 || paused !== 1'b1) begin errors++;
      $display("FAIL rcmd_pre level/paused got %0d/%0b want 3/1", fifo_level, paused); end
    send(8'h52);
    ifc.cmd_ready = 1'b1;
    step();
    ifc.cmd_ready = 1'b0;
    checks++; if (fifo_level !== 3'd1 || ifc.cmd_code !== CMD_RESET || paused !== 1'b0) begin errors++;
      $display("FAIL rcmd_flush level/code/paused got %0d/%0d/%0b want 1/%0d/0", fifo_level, ifc.cmd_code, paused, CMD_RESET); end
    d0 = m_drop;
    send(8'h31); step();
    checks++; if (fifo_level !== 3'd2 || drop_cnt !== 8'(d0)) begin errors++;
      $display("FAIL rcmd_flap level/drop got %0d/%0d want 2/%0d", fifo_level, drop_cnt, d0); end
    ifc.cmd_ready = 1'b1;
    step();
    checks++; if (ifc.cmd_code !== CMD_FLAP) begin errors++; $display("FAIL rcmd_second code got %0d want %0d", ifc.cmd_code, CMD_FLAP); end
    step();
  endtask

  task automatic test_pause_flap();
    int d0;
    ifc.cmd_ready = 1'b1;
    idle(GAP + 2);
    d0 = m_drop;
    send(8'h50); step();
    checks++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== CMD_PAUSE) begin errors++;
      $display("FAIL pause_out valid/code got %0b/%0d want 1/%0d", ifc.cmd_valid, ifc.cmd_code, CMD_PAUSE); end
    step();
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_set got %0b want 1", paused); end
    send(8'h31); idle(2);
    checks++; if (drop_cnt !== 8'(d0 + 1) || ifc.cmd_valid !== 1'b0) begin errors++;
      $display("FAIL pause_flapdrop drop/valid got %0d/%0b want %0d/0", drop_cnt, ifc.cmd_valid, d0 + 1); end
    send(8'h73); step();
    checks++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== CMD_START) begin errors++;
      $display("FAIL start_out valid/code got %0b/%0d want 1/%0d", ifc.cmd_valid, ifc.cmd_code, CMD_START); end
    step();
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL start_clear got %0b want 0", paused); end
    send(8'h31); step();
    checks++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== CMD_FLAP) begin errors++;
      $display("FAIL resume_flap valid/code got %0b/%0d want 1/%0d", ifc.cmd_valid, ifc.cmd_code, CMD_FLAP); end
    idle(2);
  endtask

  task automatic test_link_reset();
    int d0;
    ifc.cmd_ready = 1'b1;
    d0 = m_drop;
    send(8'h41); step();
    checks++; if (link_active !== 1'b1 || fifo_level !== 3'd0 || drop_cnt !== 8'(d0)) begin errors++;
      $display("FAIL unknown_byte link/level/drop got %0b/%0d/%0d want 1/0/%0d", link_active, fifo_level, drop_cnt, d0); end
    idle(LTO - 2);
    checks++; if (link_active !== 1'b1) begin errors++; $display("FAIL link_hold got %0b want 1", link_active); end
    step();
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL link_timeout got %0b want 0", link_active); end
    ifc.cmd_ready = 1'b0;
    send(8'h53); step();
    send(8'h50);
    rst_n = 1'b0; model_reset();
    #1;
    checks++; if ({ifc.cmd_valid, paused, link_active, drop_cnt, fifo_level} !== 14'd0) begin errors++;
      $display("FAIL midreset valid/paused/link/drop/level got %0b/%0b/%0b/%0d/%0d want all 0",
               ifc.cmd_valid, paused, link_active, drop_cnt, fifo_level); end
    step();
    rst_n = 1'b1;
    send(8'h70); step();
    checks++; if (paused !== 1'b1 || fifo_level !== 3'd1 || ifc.cmd_code !== CMD_PAUSE) begin errors++;
      $display("FAIL post_reset paused/level/code got %0b/%0d/%0d want 1/1/%0d", paused, fifo_level, ifc.cmd_code, CMD_PAUSE); end
  endtask

  task automatic test_random();
    logic [7:0] tbl [10] = '{8'h31, 8'h31, 8'h31, 8'h53, 8'h73, 8'h50, 8'h70, 8'h52, 8'h72, 8'h41};
    logic [15:0] act, expv;
    int cd = 0;
    for (int n = 0; n < 800; n++) begin
      ifc.cmd_ready = 1'($urandom_range(0, 1));
      if (cd == 0 && $urandom_range(0, 2) == 0) begin
        send(tbl[$urandom_range(0, 9)]); cd = 2;
      end else begin
        step(); if (cd > 0) cd--;
      end
      act  = {ifc.cmd_valid, (ifc.cmd_valid ? ifc.cmd_code : CMD_FLAP), paused, link_active, drop_cnt, fifo_level};
      expv = {mq.size() > 0, (mq.size() > 0 ? mq[0] : CMD_FLAP), m_paused, m_link(), 8'(m_drop), 3'(mq.size())};
      checks++; if (act !== expv) begin errors++;
        $display("FAIL random[%0d] {valid,code,paused,link,drop,level} got %h want %h", n, act, expv); end
    end
  endtask

  task automatic test_saturation();
    ifc.cmd_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin send(8'h53); idle(2); end
    checks++; if (drop_cnt !== 8'hFF || fifo_level !== 3'd4) begin errors++;
      $display("FAIL sat_drop drop/level got %0d/%0d want 255/4", drop_cnt, fifo_level); end
    send(8'h73); idle(2);
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold drop got %0d want 255", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_flap();
    test_flap_gap();
    test_fifo_full();
    test_reset_cmd();
    test_pause_flap();
    test_link_reset();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
